// File: rtl/async_link_pkg.sv
// Shared definitions for the async serial link: field widths, TX queue FSM states
// and the packed command/data word carried through the TX queue.
package async_link_pkg;

   localparam int CMD_W  = 8;
   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } tx_state_t;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] data;
   } tx_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO: head entry visible combinationally, count/full registered.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [AW:0]      r_count;
   logic [AW:0]      w_count_nxt;
   logic             r_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && (!r_full || w_do_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CNT_ONE;
      end else if (!w_do_push && w_do_pop) begin
         w_count_nxt = r_count - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_do_push) r_tail <= r_tail + PTR_ONE;
         if (w_do_pop)  r_head <= r_head + PTR_ONE;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_CNT);
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_tail] <= i_push_dat;
   end

   assign o_head_dat = r_mem[r_head];
   assign o_full     = r_full;
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/async_tx_queue.sv
// Queues host command/data words and feeds them one at a time to the async transmitter.
// tx_ready pulses 2 cycles after a word is loaded; pushes while full are dropped and flag overflow.
module async_tx_queue
   import async_link_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int START_TIMEOUT = 64,
   parameter int MAX_RETRY     = 3
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   wr_en,
   input  logic [CMD_W-1:0]       wr_command,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   clear_overflow,
   output logic [CMD_W-1:0]       tx_command,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   tx_ready,
   input  logic                   tx_ndone,
   output logic                   busy,
   output logic [7:0]             drop_count
);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(START_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE   = TW'(1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [RW-1:0] RETRY_ONE = RW'(1);

   tx_state_t              r_state;
   tx_state_t              w_state_nxt;
   tx_word_t               w_push_word;
   tx_word_t               w_head_word;
   logic                   w_empty;
   logic                   w_full;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_load;
   logic                   w_retry_inc;
   logic                   w_drop;
   logic                   w_ovf_set;
   logic [TW-1:0]          r_timer;
   logic [RW-1:0]          r_retry;
   logic                   r_tx_ready;
   logic [CMD_W-1:0]       r_tx_command;
   logic [DATA_W-1:0]      r_tx_data;
   logic                   r_overflow;
   logic [7:0]             r_drop_count;

   assign w_push_word = '{cmd: wr_command, data: wr_data};

   sync_fifo #(
      .WIDTH ($bits(tx_word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .nreset     (nreset),
      .i_push     (wr_en),
      .i_push_dat (w_push_word),
      .i_pop      (w_load),
      .o_head_dat (w_head_word),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   // A full queue still accepts a push in the cycle the FSM pops.
   assign w_ovf_set = wr_en && w_full && !w_load;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_retry_inc = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_load      = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (tx_ndone) begin
               w_state_nxt = ST_WAIT_DONE;
            end else if (r_timer == TMO_LAST) begin
               if (r_retry < RETRY_MAX) begin
                  w_retry_inc = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_drop      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_ndone) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_timer      <= '0;
         r_retry      <= '0;
         r_tx_ready   <= 1'b0;
         r_tx_command <= '0;
         r_tx_data    <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         // The pulse lands in the first WAIT_BUSY cycle, while the timer sits at 0.
         r_tx_ready <= (r_state == ST_ISSUE);
         if (w_load) begin
            r_tx_command <= w_head_word.cmd;
            r_tx_data    <= w_head_word.data;
            r_retry      <= '0;
         end
         if (r_state == ST_ISSUE)          r_timer <= '0;
         else if (r_state == ST_WAIT_BUSY) r_timer <= r_timer + TMO_ONE;
         if (w_retry_inc) r_retry <= r_retry + RETRY_ONE;
         if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
         if (w_ovf_set)           r_overflow <= 1'b1;
         else if (clear_overflow) r_overflow <= 1'b0;
      end
   end

   assign full       = w_full;
   assign count      = w_count;
   assign overflow   = r_overflow;
   assign tx_command = r_tx_command;
   assign tx_data    = r_tx_data;
   assign tx_ready   = r_tx_ready;
   assign busy       = (r_state != ST_IDLE);
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_async_tx_queue.sv
// Directed bench for async_tx_queue: vector table for fill/overflow, hand sequences for
// single word, drain order, no-ack drop, late ack and reset mid-transfer.
module tb_async_tx_queue;
   import async_link_pkg::*;

   logic        clk = 1'b0;
   logic        nreset;
   logic        wr_en;
   logic [7:0]  wr_command;
   logic [63:0] wr_data;
   logic        full;
   logic [4:0]  count;
   logic        overflow;
   logic        clear_overflow;
   logic [7:0]  tx_command;
   logic [63:0] tx_data;
   logic        tx_ready;
   logic        tx_ndone;
   logic        busy;
   logic [7:0]  drop_count;

   always #5 clk = ~clk;

   async_tx_queue #(.DEPTH(16), .START_TIMEOUT(64), .MAX_RETRY(3)) dut (
      .clk            (clk),
      .nreset         (nreset),
      .wr_en          (wr_en),
      .wr_command     (wr_command),
      .wr_data        (wr_data),
      .full           (full),
      .count          (count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .tx_command     (tx_command),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .tx_ndone       (tx_ndone),
      .busy           (busy),
      .drop_count     (drop_count)
   );

   // Transmitter model: ignores xm_skip pulses, then holds ndone high for xm_len cycles.
   int          cyc = 0;
   int          xm_rem = 0;
   int          xm_len = 0;
   int          xm_skip = 0;
   int          xm_fall_cyc = 0;
   logic        xm_busy = 1'b0;
   logic        force_en = 1'b1;
   logic        force_val = 1'b0;
   int          p_cyc[$];
   logic [7:0]  p_cmd[$];
   logic [63:0] p_dat[$];

   assign tx_ndone = force_en ? force_val : xm_busy;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (xm_rem > 0) begin
            xm_busy = 1'b1;
            xm_rem--;
         end else begin
            if (xm_busy) xm_fall_cyc = cyc;
            xm_busy = 1'b0;
         end
         if (tx_ready) begin
            p_cyc.push_back(cyc);
            p_cmd.push_back(tx_command);
            p_dat.push_back(tx_data);
            if (xm_skip > 0) xm_skip--;
            else             xm_rem = xm_len;
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic clr_log();
      p_cyc.delete();
      p_cmd.delete();
      p_dat.delete();
   endtask

   task automatic push(input logic [7:0] c, input logic [63:0] d);
      wr_en      = 1'b1;
      wr_command = c;
      wr_data    = d;
      step();
      wr_en      = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, tx_ready, 0);
      chk({tag, "_cmd"}, tx_command, 0);
      chk({tag, "_data"}, tx_data, 0);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_drops"}, drop_count, 0);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] cmd;
      logic       nd;
      logic       clr;
      logic [4:0] e_count;
      logic       e_full;
      logic       e_ovf;
      logic       e_busy;
      logic       e_rdy;
      logic [7:0] e_cmd;
   } vec_t;

   vec_t tbl[26];

   task automatic setv(input int i, input logic wr, input logic [7:0] cmd, input logic nd,
                       input logic clr, input logic [4:0] cnt, input logic f, input logic ov,
                       input logic b, input logic r, input logic [7:0] ec);
      tbl[i] = '{wr, cmd, nd, clr, cnt, f, ov, b, r, ec};
   endtask

   initial begin
      int t;
      nreset         = 1'b0;
      wr_en          = 1'b0;
      wr_command     = '0;
      wr_data        = '0;
      clear_overflow = 1'b0;

      // A prior word occupies the transmitter, then 17 pushes and full-queue corner cases.
      setv(0, 1, 8'hA0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
      setv(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'hA0);
      setv(2, 0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 8'hA0);
      setv(3, 1, 8'h00, 1, 0, 1, 0, 0, 1, 0, 8'hA0);
      for (int k = 1; k < 16; k++)
         setv(3 + k, 1, 8'(k), 1, 0, 5'(k + 1), (k == 15), 0, 1, 0, 8'hA0);
      setv(19, 1, 8'h10, 1, 0, 16, 1, 1, 1, 0, 8'hA0);
      setv(20, 0, 8'h00, 1, 0, 16, 1, 1, 1, 0, 8'hA0);
      setv(21, 0, 8'h00, 0, 0, 16, 1, 1, 0, 0, 8'hA0);
      setv(22, 1, 8'h20, 0, 0, 16, 1, 1, 1, 0, 8'h00);
      setv(23, 0, 8'h00, 1, 1, 16, 1, 0, 1, 1, 8'h00);
      setv(24, 1, 8'h30, 1, 1, 16, 1, 1, 1, 0, 8'h00);
      setv(25, 0, 8'h00, 1, 1, 16, 1, 0, 1, 0, 8'h00);

      step();
      step();
      chk_reset_vals("reset");
      nreset = 1'b1;
      step();

      foreach (tbl[i]) begin
         wr_en          = tbl[i].wr;
         wr_command     = tbl[i].cmd;
         wr_data        = {8{tbl[i].cmd}};
         force_val      = tbl[i].nd;
         clear_overflow = tbl[i].clr;
         step();
         chk($sformatf("v%0d_count", i), count, tbl[i].e_count);
         chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
         chk($sformatf("v%0d_ovf", i), overflow, tbl[i].e_ovf);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("v%0d_ready", i), tx_ready, tbl[i].e_rdy);
         chk($sformatf("v%0d_cmd", i), tx_command, tbl[i].e_cmd);
         chk($sformatf("v%0d_data", i), tx_data, {8{tbl[i].e_cmd}});
      end
      wr_en          = 1'b0;
      clear_overflow = 1'b0;

      // Drain: words 1..15 then the word pushed during the full-queue pop; 0x10 and 0x30 never.
      xm_len = 3;
      clr_log();
      force_en = 1'b0;
      t = 0;
      while ((p_cmd.size() < 16 || busy) && t < 600) begin step(); t++; end
      chk("drain_pulses", p_cmd.size(), 16);
      for (int i = 0; i < 16 && i < p_cmd.size(); i++) begin
         chk($sformatf("drain_cmd%0d", i), p_cmd[i], (i < 15) ? 8'(i + 1) : 8'h20);
         chk($sformatf("drain_dat%0d", i), p_dat[i], (i < 15) ? {8{8'(i + 1)}} : {8{8'h20}});
      end
      chk("drain_count", count, 0);
      chk("drain_full", full, 0);

      // Single word with a long frame.
      xm_len = 700;
      clr_log();
      t = cyc;
      push(8'h42, 64'h123456789abcdeff);
      chk("sw_count", count, 1);
      while (p_cmd.size() == 0 && cyc < t + 20) step();
      chk("sw_pulses", p_cmd.size(), 1);
      if (p_cmd.size() > 0) begin
         chk("sw_latency", p_cyc[0] - t, 3);
         chk("sw_cmd", p_cmd[0], 8'h42);
         chk("sw_data", p_dat[0], 64'h123456789abcdeff);
         t = 0;
         while (busy && t < 1000) begin step(); t++; end
         chk("sw_ndone_len", xm_fall_cyc - p_cyc[0] - 1, 700);
         chk("sw_busy_drop", cyc - xm_fall_cyc, 1);
      end
      chk("sw_one_pulse", p_cmd.size(), 1);
      chk("sw_data_held", tx_data, 64'h123456789abcdeff);

      // No acknowledge: each word gets 4 attempts then is dropped.
      xm_skip = 1000;
      clr_log();
      push(8'h51, 64'h0000111122225151);
      push(8'h52, 64'h0000333344445252);
      t = 0;
      while (p_cmd.size() < 5 && t < 500) begin step(); t++; end
      chk("na_drops_first", drop_count, 1);
      t = 0;
      while ((p_cmd.size() < 8 || busy) && t < 600) begin step(); t++; end
      chk("na_pulses", p_cmd.size(), 8);
      chk("na_drops", drop_count, 2);
      if (p_cmd.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("na_cmd%0d", i), p_cmd[i], (i < 4) ? 8'h51 : 8'h52);
            chk($sformatf("na_dat%0d", i), p_dat[i],
                (i < 4) ? 64'h0000111122225151 : 64'h0000333344445252);
         end
         for (int i = 0; i < 7; i++)
            chk($sformatf("na_gap%0d", i), p_cyc[i + 1] - p_cyc[i], (i == 3) ? 66 : 65);
      end

      // Late acknowledge on the second attempt.
      xm_skip = 1;
      xm_len  = 20;
      clr_log();
      push(8'h61, 64'hFEEDFACE01234567);
      t = 0;
      while ((p_cmd.size() < 2 || busy) && t < 300) begin step(); t++; end
      repeat (20) step();
      chk("la_pulses", p_cmd.size(), 2);
      if (p_cmd.size() >= 2) begin
         chk("la_gap", p_cyc[1] - p_cyc[0], 65);
         chk("la_cmd", p_cmd[1], 8'h61);
         chk("la_data0", p_dat[0], 64'hFEEDFACE01234567);
         chk("la_data1", p_dat[1], 64'hFEEDFACE01234567);
      end
      chk("la_drops", drop_count, 2);
      chk("la_busy", busy, 0);

      // Reset while the transmitter is mid-frame with 5 words queued.
      xm_skip = 0;
      xm_len  = 200;
      clr_log();
      for (int i = 0; i < 6; i++) push(8'(8'h70 + i), {8{8'(8'h70 + i)}});
      t = 0;
      while (!(tx_ndone && busy) && t < 50) begin step(); t++; end
      step();
      chk("rm_count", count, 5);
      chk("rm_busy", busy, 1);
      nreset = 1'b0;
      step();
      chk_reset_vals("rm");
      nreset = 1'b1;
      clr_log();
      repeat (250) step();
      chk("rm_no_pulse", p_cmd.size(), 0);
      chk("rm_idle", busy, 0);
      xm_len = 5;
      push(8'h7F, 64'h7F7F7F7F00000001);
      t = 0;
      while ((p_cmd.size() == 0 || busy) && t < 60) begin step(); t++; end
      chk("rm_new_pulses", p_cmd.size(), 1);
      if (p_cmd.size() > 0) chk("rm_new_cmd", p_cmd[0], 8'h7F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
